// File: rtl/ioctl_pkg.sv
// rtl/ioctl_pkg.sv - shared types and constants for the ioctl download initiator
package ioctl_pkg;

    localparam int          IOCTL_ADDR_W = 25;
    localparam logic [7:0]  IDX_BIOS     = 8'd0;
    localparam int          GAP_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FETCH = 3'd2,
        ST_LATCH = 3'd3,
        ST_ISSUE = 3'd4,
        ST_GAP   = 3'd5,
        ST_TAIL  = 3'd6
    } ioctl_state_e;

endpackage

// File: rtl/ioctl_stream_tx.sv
// rtl/ioctl_stream_tx.sv - ioctl download initiator streaming a source memory image
module ioctl_stream_tx
    import ioctl_pkg::*;
#(
    parameter int ADDR_W = IOCTL_ADDR_W,
    parameter int GAP    = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_rd,
    input  logic [7:0]        src_data,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic              ioctl_wr,
    input  logic              ioctl_wait
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    ioctl_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              src_rd_q, src_rd_d;
    logic              dl_q, dl_d;
    logic [7:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              wr_q, wr_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        gap_d      = gap_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        src_addr_d = src_addr_q;
        src_rd_d   = 1'b0;
        dl_d       = dl_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        wr_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        len_d   = length;
                        idx_d   = index;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dl_d    = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                addr_d     = '0;
                src_rd_d   = 1'b1;
                src_addr_d = cnt_q;
                state_d    = ST_FETCH;
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                dout_d  = src_data;
                addr_d  = cnt_q;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // The strobe is only held back here; a stall during GAP is ignored.
                if (!ioctl_wait) begin
                    wr_d    = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (cnt_q == len_q - ONE) begin
                    state_d = ST_TAIL;
                end else begin
                    cnt_d      = cnt_q + ONE;
                    src_rd_d   = 1'b1;
                    src_addr_d = cnt_q + ONE;
                    state_d    = ST_FETCH;
                end
            end
            ST_TAIL: begin
                dl_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_addr_q <= '0;
            src_rd_q   <= 1'b0;
            dl_q       <= 1'b0;
            idx_q      <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            src_addr_q <= src_addr_d;
            src_rd_q   <= src_rd_d;
            dl_q       <= dl_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign src_addr       = src_addr_q;
    assign src_rd         = src_rd_q;
    assign ioctl_download = dl_q;
    assign ioctl_index    = idx_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign ioctl_wr       = wr_q;

endmodule

// File: tb/tb_ioctl_stream_tx.sv
// tb/tb_ioctl_stream_tx.sv - self-checking bench for ioctl_stream_tx
module tb_ioctl_stream_tx;
    import ioctl_pkg::*;

    localparam int AW  = 25;
    localparam int GAP = 2;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          start   = 1'b0;
    logic [7:0]    index   = 8'd0;
    logic [AW-1:0] length  = '0;
    logic          busy, done, src_rd, ioctl_download, ioctl_wr;
    logic [AW-1:0] src_addr, ioctl_addr;
    logic [7:0]    src_data, ioctl_index, ioctl_dout;
    logic          wait_force = 1'b0, wait_rand = 1'b0, rnd_q = 1'b0;
    logic          ioctl_wait;

    assign ioctl_wait = wait_rand ? rnd_q : wait_force;

    ioctl_stream_tx #(.ADDR_W(AW), .GAP(GAP)) dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .index(index), .length(length),
        .busy(busy), .done(done), .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait)
    );

    always #5 clk_sys = ~clk_sys;

    // source memory with one-cycle read latency
    logic [7:0] mem [0:8191];
    always @(posedge clk_sys) if (src_rd) src_data <= mem[src_addr[12:0]];

    always @(posedge clk_sys) begin
        #1 rnd_q <= ($urandom_range(0, 2) == 0);
    end

    // passive monitor: records every write strobe and window/handshake events
    int            cyc = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0, busy_rise = 0;
    logic          prev_wait = 1'b0, prev_dl = 1'b0, prev_busy = 1'b0;
    logic [AW-1:0] wa_q[$];
    logic [7:0]    wd_q[$];
    logic [7:0]    wi_q[$];
    int            wc_q[$];
    logic          wpw_q[$];

    always @(negedge clk_sys) begin
        cyc++;
        if (ioctl_wr) begin
            wa_q.push_back(ioctl_addr);
            wd_q.push_back(ioctl_dout);
            wi_q.push_back(ioctl_index);
            wc_q.push_back(cyc);
            wpw_q.push_back(prev_wait);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_dl && !ioctl_download) fall_cyc = cyc;
        if (!prev_busy && busy) busy_rise++;
        prev_wait = ioctl_wait;
        prev_dl   = ioctl_download;
        prev_busy = busy;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic do_start(input logic [7:0] idx, input logic [AW-1:0] len);
        start  = 1'b1;
        index  = idx;
        length = len;
        step(1);
        start  = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step(1);
            n++;
        end
        step(2);
        chk("done_single_pulse", 64'(done_cnt - d0), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic wait_writes(input int base, input int k, input int budget);
        int n = 0;
        while (wa_q.size() - base < k && n < budget) begin
            step(1);
            n++;
        end
        chk("write_progress", 64'(wa_q.size() - base >= k), 64'd1);
    endtask

    // reference: byte i goes to address i with data mem[i]; strict means wait held low
    task automatic verify(input int base, input int len, input logic [7:0] idx, input bit strict);
        int got = wa_q.size() - base;
        int lim = (got < len) ? got : len;
        int bad_addr = 0, bad_data = 0, bad_idx = 0, bad_wait = 0, bad_gap = 0;
        chk("wr_count", 64'(got), 64'(len));
        for (int i = 0; i < lim; i++) begin
            if (wa_q[base+i] !== AW'(i)) bad_addr++;
            if (wd_q[base+i] !== mem[i]) bad_data++;
            if (wi_q[base+i] !== idx) bad_idx++;
            if (wpw_q[base+i] !== 1'b0) bad_wait++;
            if (i > 0) begin
                if (strict ? (wc_q[base+i] - wc_q[base+i-1] != GAP + 4)
                           : (wc_q[base+i] - wc_q[base+i-1] <  GAP + 4)) bad_gap++;
            end
        end
        chk("addr_seq", 64'(bad_addr), 64'd0);
        chk("data_seq", 64'(bad_data), 64'd0);
        chk("index_seq", 64'(bad_idx), 64'd0);
        chk("wr_during_wait", 64'(bad_wait), 64'd0);
        chk("wr_spacing", 64'(bad_gap), 64'd0);
        if (got == len && len > 0) begin
            chk("dl_fall_delay", 64'(fall_cyc - wc_q[base+len-1]), 64'(GAP + 2));
            chk("done_at_fall", 64'(done_cyc), 64'(fall_cyc));
        end
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
    endtask

    int base, base2, d0, br, n0, rlen;
    logic [7:0] ridx;
    logic [39:0] hdr;

    initial begin
        step(2);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_download", 64'(ioctl_download), 64'd0);
        chk("rst_wr", 64'(ioctl_wr), 64'd0);
        chk("rst_src_rd", 64'(src_rd), 64'd0);
        chk("rst_addr", 64'(ioctl_addr), 64'd0);
        reset = 1'b0;
        step(1);

        // basic 4-byte transfer
        for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
        base = wa_q.size();
        do_start(8'd5, AW'(4));
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_download", 64'(ioctl_download), 64'd1);
        chk("start_index", 64'(ioctl_index), 64'd5);
        run_until_done(200);
        verify(base, 4, 8'd5, 1'b1);
        chk("addr_hold", 64'(ioctl_addr), 64'd3);
        chk("dout_hold", 64'(ioctl_dout), 64'hA3);
        chk("download_off", 64'(ioctl_download), 64'd0);

        // bios image
        fill_random(4096);
        base = wa_q.size();
        do_start(IDX_BIOS, AW'(4096));
        run_until_done(40000);
        verify(base, 4096, IDX_BIOS, 1'b1);

        // cart image with header
        fill_random(200);
        hdr = "ATARI";
        for (int i = 0; i < 5; i++) mem[i] = hdr[39-8*i -: 8];
        base = wa_q.size();
        do_start(8'd1, AW'(200));
        run_until_done(3000);
        verify(base, 200, 8'd1, 1'b1);
        if (wa_q.size() - base >= 5)
            chk("cart_header", {wd_q[base], wd_q[base+1], wd_q[base+2], wd_q[base+3], wd_q[base+4]},
                64'(hdr));

        // receiver stall at address 5
        fill_random(8);
        base = wa_q.size();
        do_start(8'd2, AW'(8));
        wait_writes(base, 5, 200);
        wait_force = 1'b1;
        n0 = 0;
        while (ioctl_addr != AW'(5) && n0 < 50) begin
            step(1);
            n0++;
        end
        n0 = wa_q.size();
        step(10);
        chk("stall_no_wr", 64'(wa_q.size() - n0), 64'd0);
        wait_force = 1'b0;
        step(1);
        chk("stall_wr_after", 64'(ioctl_wr), 64'd1);
        chk("stall_wr_addr", 64'(ioctl_addr), 64'd5);
        chk("stall_wr_data", 64'(ioctl_dout), 64'(mem[5]));
        run_until_done(300);
        verify(base, 8, 8'd2, 1'b0);

        // zero length
        br = busy_rise;
        d0 = done_cnt;
        do_start(8'd3, AW'(0));
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_download", 64'(ioctl_download), 64'd0);
        step(3);
        chk("zero_no_busy_rise", 64'(busy_rise - br), 64'd0);
        chk("zero_done_once", 64'(done_cnt - d0), 64'd1);

        // start while busy is ignored
        fill_random(10);
        base = wa_q.size();
        do_start(8'd1, AW'(3));
        step(4);
        do_start(8'd9, AW'(10));
        run_until_done(300);
        verify(base, 3, 8'd1, 1'b1);

        // asynchronous reset mid-transfer
        fill_random(8);
        base = wa_q.size();
        do_start(8'd7, AW'(8));
        wait_writes(base, 4, 200);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_download", 64'(ioctl_download), 64'd0);
        chk("arst_addr", 64'(ioctl_addr), 64'd0);
        chk("arst_dout", 64'(ioctl_dout), 64'd0);
        chk("arst_index", 64'(ioctl_index), 64'd0);
        chk("arst_src", 64'({src_rd, src_addr}), 64'd0);
        step(2);
        reset = 1'b0;
        n0 = wa_q.size();
        step(5);
        chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("arst_no_wr", 64'(wa_q.size() - n0), 64'd0);
        fill_random(2);
        base2 = wa_q.size();
        do_start(8'd4, AW'(2));
        run_until_done(200);
        verify(base2, 2, 8'd4, 1'b1);

        // randomized lengths, indices and wait pattern
        wait_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            rlen = $urandom_range(1, 30);
            ridx = 8'($urandom);
            fill_random(rlen);
            base = wa_q.size();
            do_start(ridx, AW'(rlen));
            run_until_done(rlen * 60 + 50);
            verify(base, rlen, ridx, 1'b0);
        end
        wait_rand = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
